n_x_serdes_8_to_1_tx_framer: RTL and testbench
==============================================

Name: n_x_serdes_8_to_1_tx_framer

Overview:
Transmit-side framer for N channels of D data lanes plus one forwarded-clock lane per channel. It runs in the parallel (divided) clock domain and produces one 8-bit word per lane per cycle for downstream 8:1 DDR output serializers. After enable, it sends a fixed training sequence, then one sync word, then user payload. The payload is taken from an upstream valid/ready interface. The training phase lets the far-end 1:8 receiver finish MMCM phase search and bitslip before real data arrives.

Parameters:
N, 4, number of channels
D, 8, data lanes per channel
CLK_PATTERN, 8'b11110000, word driven on every forwarded-clock lane
TRAIN_WORD, 8'h5C, word driven on all data lanes during TRAIN
SYNC_WORD, 8'hBC, word driven on all data lanes for the single SYNC cycle
IDLE_WORD, 8'h00, word driven on data lanes in IDLE and when DATA has no valid beat
TRAIN_CYCLES, 256, length of TRAIN in cycles; legal range 1..65535

Ports:
txclk_div  in  1  parallel-word clock; the only clock
reset  in  1  reset, synchronous, active-high
tx_enable  in  1  level; 1 = run, 0 = return to IDLE
train_req  in  1  pulse or level; (re)starts training
s_data  in  N*D*8  payload; byte lane k = s_data[8k+7:8k], k = i*D+j (channel i, lane j)
s_valid  in  1  payload valid
s_ready  out  1  payload ready
clk_data  out  N*8  forwarded-clock words, channel i at [8i+7:8i]
tx_data  out  N*D*8  data-lane words, same lane mapping as s_data
training  out  1  high while in TRAIN
tx_state  out  2  00 IDLE, 01 TRAIN, 10 SYNC, 11 DATA
word_count  out  32  count of accepted payload beats

Behaviour:
- All state changes on rising txclk_div. All outputs except s_ready are registered.
- Reset (synchronous, active-high) values: state=IDLE, clk_data=0, tx_data=0, training=0, word_count=0, train counter=0. s_ready is 0 while reset is high.
- clk_data = {N{CLK_PATTERN}} every cycle after reset deasserts, independent of state. The first pattern word appears one cycle after the reset-low edge.
- IDLE: tx_data = IDLE_WORD on all lanes. If tx_enable=1, go to TRAIN next cycle and clear the counter.
- TRAIN:
  - tx_data = TRAIN_WORD on all lanes; training=1.
  - Counter increments each cycle.
  - When counter == TRAIN_CYCLES-1, go to SYNC. TRAIN therefore lasts exactly TRAIN_CYCLES cycles.
- SYNC: tx_data = SYNC_WORD on all lanes for exactly 1 cycle, then go to DATA.
- DATA:
  - s_ready = (state==DATA) & tx_enable & ~train_req. This is combinational; it is the only unregistered output.
  - A beat is accepted when s_valid & s_ready. Its data appears on tx_data the next cycle (latency 1), and word_count increments by 1.
  - Any cycle in DATA without an accepted beat drives IDLE_WORD.
- word_count wraps from 32'hFFFFFFFF to 0. It is not cleared by retraining; only reset clears it.
- Priority, highest first:
  1. reset
  2. tx_enable=0: go to IDLE next cycle from any state.
  3. train_req=1 with tx_enable=1: go to TRAIN next cycle from any state, counter cleared. This includes TRAIN itself, so a held train_req keeps TRAIN extended indefinitely.
  4. normal transitions.
- Beats are never accepted in the cycle a transition out of DATA is requested. No payload beat is dropped or duplicated.
- Reset asserted mid-TRAIN or mid-DATA aborts immediately. Outputs take their reset values the next cycle.

Optional Feature:
Macro TX_PRBS_TRAIN_EN.
- Defined: during TRAIN each lane drives the next 8 bits of a PRBS7 sequence (x^7+x^6+1) instead of TRAIN_WORD.
  - One shared 7-bit LFSR is seeded to 7'h7F on entry to TRAIN.
  - It advances 8 bits per cycle; bit 0 of the word is the earliest bit.
  - All lanes carry the same word.
- Undefined: TRAIN_WORD is used and no LFSR logic exists.

Test Plan:
- Reset release, N=2, D=2, TRAIN_CYCLES=8, tx_enable=0 → clk_data=16'hF0F0 from cycle 1, tx_data all 00, tx_state=00, s_ready=0.
- tx_enable rises at cycle 5 → tx_state=01 for cycles 6..13 with tx_data all 5C and training=1; cycle 14 SYNC with all BC; cycle 15 DATA with s_ready=1.
- In DATA, s_valid=1 for 3 cycles with s_data=32'h11223344, 55667788, 99AABBCC → same words on tx_data one cycle later each, then 00 fill; word_count=3.
- train_req pulsed while s_valid=1 in DATA → s_ready=0 that cycle; no beat accepted; word_count unchanged; TRAIN lasts 8 cycles, then SYNC, then DATA.
- tx_enable dropped mid-TRAIN at count 4 → IDLE next cycle. Re-enable gives a full 8-cycle TRAIN.
- word_count forced to FFFFFFFF, one accepted beat → word_count=0. With TX_PRBS_TRAIN_EN defined, the first TRAIN word matches the reference PRBS7 model from seed 7F.

Source files
------------

// File: rtl/n_x_serdes_8_to_1_tx_framer.sv
// -----------------------------------------------------------------------------
// n_x_serdes_8_to_1_tx_framer
//
// Transmit framer for N channels of D data lanes plus one forwarded-clock lane
// per channel. It runs in the divided (parallel-word) clock domain and emits
// one 8-bit word per lane per cycle for downstream 8:1 DDR serializers.
// Sequence after enable: TRAIN (TRAIN_CYCLES cycles), one SYNC word, then
// payload taken from a valid/ready stream.
//
// Optional feature macro: TX_PRBS_TRAIN_EN
//   Defined   : TRAIN lanes carry a PRBS7 (x^7+x^6+1) stream, 8 bits per cycle,
//               from one shared LFSR seeded to 7'h7F on every entry to TRAIN.
//   Undefined : TRAIN lanes carry TRAIN_WORD; no LFSR exists.
//
// Ports
//   txclk_div  in   parallel-word clock (only clock)
//   reset      in   synchronous, active-high reset
//   tx_enable  in   level, 1 = run, 0 = return to IDLE
//   train_req  in   (re)starts training while enabled
//   s_data     in   payload, byte lane k = s_data[8k+7:8k], k = i*D+j
//   s_valid    in   payload valid
//   s_ready    out  payload ready (combinational)
//   clk_data   out  forwarded-clock words, channel i at [8i+7:8i]
//   tx_data    out  data-lane words, same mapping as s_data
//   training   out  high while in TRAIN
//   tx_state   out  00 IDLE, 01 TRAIN, 10 SYNC, 11 DATA
//   word_count out  number of accepted payload beats (wraps)
// -----------------------------------------------------------------------------
module n_x_serdes_8_to_1_tx_framer #(
    parameter int           N            = 4,
    parameter int           D            = 8,
    parameter logic [7:0]   CLK_PATTERN  = 8'b11110000,
    parameter logic [7:0]   TRAIN_WORD   = 8'h5C,
    parameter logic [7:0]   SYNC_WORD    = 8'hBC,
    parameter logic [7:0]   IDLE_WORD    = 8'h00,
    parameter int           TRAIN_CYCLES = 256
) (
    input  logic               txclk_div,
    input  logic               reset,
    input  logic               tx_enable,
    input  logic               train_req,
    input  logic [N*D*8-1:0]   s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [N*8-1:0]     clk_data,
    output logic [N*D*8-1:0]   tx_data,
    output logic               training,
    output logic [1:0]         tx_state,
    output logic [31:0]        word_count
);

    localparam int LANES = N * D;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_TRAIN = 2'b01,
        ST_SYNC  = 2'b10,
        ST_DATA  = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [N*8-1:0]     clk_data_q, clk_data_d;
    logic [N*D*8-1:0]   tx_data_q, tx_data_d;
    logic               training_q, training_d;
    logic [31:0]        word_count_q, word_count_d;
    logic               accept;
    logic               enter_train;
    logic [7:0]         train_byte;

`ifdef TX_PRBS_TRAIN_EN
    logic [6:0]         lfsr_q, lfsr_d;
    logic [6:0]         lfsr_base;

    // Advance the LFSR 8 steps; bit 0 of the returned word is the earliest bit.
    // Result layout: {next_state[6:0], word[7:0]}.
    function automatic logic [14:0] prbs7_step8(input logic [6:0] seed);
        logic [6:0] s;
        logic [7:0] w;
        logic       fb;
        s = seed;
        w = 8'h00;
        for (int i = 0; i < 8; i++) begin
            fb   = s[6] ^ s[5];
            w[i] = fb;
            s    = {s[5:0], fb};
        end
        return {s, w};
    endfunction
`endif

    // A beat only moves while we are settled in DATA and no transition is
    // pending, so nothing is taken in the cycle we leave DATA.
    assign s_ready = (state_q == ST_DATA) & tx_enable & ~train_req & ~reset;
    assign accept  = s_valid & s_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        enter_train  = 1'b0;
        word_count_d = accept ? word_count_q + 32'd1 : word_count_q;
        clk_data_d   = {N{CLK_PATTERN}};

        if (!tx_enable) begin
            state_d = ST_IDLE;
        end else if (train_req) begin
            state_d     = ST_TRAIN;
            cnt_d       = 16'd0;
            enter_train = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d     = ST_TRAIN;
                    cnt_d       = 16'd0;
                    enter_train = 1'b1;
                end
                ST_TRAIN: begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == 16'(TRAIN_CYCLES - 1)) begin
                        state_d = ST_SYNC;
                    end
                end
                ST_SYNC:  state_d = ST_DATA;
                default:  state_d = ST_DATA;
            endcase
        end

`ifdef TX_PRBS_TRAIN_EN
        lfsr_base = enter_train ? 7'h7F : lfsr_q;
        lfsr_d    = lfsr_q;
        {lfsr_d, train_byte} = {lfsr_q, TRAIN_WORD};
        if (state_d == ST_TRAIN) begin
            {lfsr_d, train_byte} = prbs7_step8(lfsr_base);
        end
`else
        train_byte = TRAIN_WORD;
`endif

        // Outputs are registered, so they are chosen from the state we are
        // about to occupy; this keeps tx_data aligned with tx_state.
        training_d = (state_d == ST_TRAIN);
        case (state_d)
            ST_TRAIN: tx_data_d = {LANES{train_byte}};
            ST_SYNC:  tx_data_d = {LANES{SYNC_WORD}};
            ST_DATA:  tx_data_d = accept ? s_data : {LANES{IDLE_WORD}};
            default:  tx_data_d = {LANES{IDLE_WORD}};
        endcase
    end

    always_ff @(posedge txclk_div) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 16'd0;
            clk_data_q   <= '0;
            tx_data_q    <= '0;
            training_q   <= 1'b0;
            word_count_q <= 32'd0;
`ifdef TX_PRBS_TRAIN_EN
            lfsr_q       <= 7'h7F;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            clk_data_q   <= clk_data_d;
            tx_data_q    <= tx_data_d;
            training_q   <= training_d;
            word_count_q <= word_count_d;
`ifdef TX_PRBS_TRAIN_EN
            lfsr_q       <= lfsr_d;
`endif
        end
    end

    assign clk_data   = clk_data_q;
    assign tx_data    = tx_data_q;
    assign training   = training_q;
    assign tx_state   = state_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_n_x_serdes_8_to_1_tx_framer.sv
// -----------------------------------------------------------------------------
// Directed bench for n_x_serdes_8_to_1_tx_framer with N=2, D=2, TRAIN_CYCLES=8.
// Inputs change #1 after the rising edge; outputs are checked there as well.
// -----------------------------------------------------------------------------
module tb_n_x_serdes_8_to_1_tx_framer;

    localparam int N  = 2;
    localparam int D  = 2;
    localparam int TC = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              tx_enable;
    logic              train_req;
    logic [N*D*8-1:0]  s_data;
    logic              s_valid;
    logic              s_ready;
    logic [N*8-1:0]    clk_data;
    logic [N*D*8-1:0]  tx_data;
    logic              training;
    logic [1:0]        tx_state;
    logic [31:0]       word_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    n_x_serdes_8_to_1_tx_framer #(
        .N(N), .D(D), .TRAIN_CYCLES(TC)
    ) dut (
        .txclk_div (clk),
        .reset     (reset),
        .tx_enable (tx_enable),
        .train_req (train_req),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .clk_data  (clk_data),
        .tx_data   (tx_data),
        .training  (training),
        .tx_state  (tx_state),
        .word_count(word_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Independent PRBS7 reference: bit n = bit(n-7) ^ bit(n-6), seed all ones.
    function automatic logic [7:0] prbs_ref_first_word();
        logic [0:14] b;
        logic [7:0]  w;
        for (int i = 0; i < 7; i++) b[i] = 1'b1;
        for (int n = 7; n < 15; n++) b[n] = b[n-7] ^ b[n-6];
        for (int i = 0; i < 8; i++) w[i] = b[7+i];
        return w;
    endfunction

    logic [7:0] train_w;

    initial begin
`ifdef TX_PRBS_TRAIN_EN
        train_w = prbs_ref_first_word();
`else
        train_w = 8'h5C;
`endif
        reset = 1'b1; tx_enable = 1'b0; train_req = 1'b0;
        s_data = '0; s_valid = 1'b0;
        step(); step();
        check("rst_clk_data",   clk_data,   16'h0000);
        check("rst_tx_data",    tx_data,    32'h0);
        check("rst_state",      tx_state,   2'b00);
        check("rst_training",   training,   1'b0);
        check("rst_word_count", word_count, 32'd0);
        check("rst_s_ready",    s_ready,    1'b0);

        // Release reset; cycle 1 onward shows the clock pattern
        reset = 1'b0;
        step();
        check("c1_clk_data", clk_data, 16'hF0F0);
        check("c1_tx_data",  tx_data,  32'h0);
        check("c1_state",    tx_state, 2'b00);
        check("c1_s_ready",  s_ready,  1'b0);
        step(); step(); step(); step();          // now in cycle 5
        check("idle_state", tx_state, 2'b00);
        tx_enable = 1'b1;

        // Cycles 6..13 TRAIN
        for (int i = 0; i < TC; i++) begin
            step();
            check("train_state", tx_state, 2'b01);
            check("train_flag",  training, 1'b1);
            if (i == 0) check("train_first_word", tx_data, {4{train_w}});
`ifndef TX_PRBS_TRAIN_EN
            check("train_data", tx_data, 32'h5C5C5C5C);
`endif
        end
        step();
        check("sync_state", tx_state, 2'b10);
        check("sync_data",  tx_data,  32'hBCBCBCBC);
        check("sync_train", training, 1'b0);
        step();
        check("data_state",   tx_state, 2'b11);
        check("data_ready",   s_ready,  1'b1);
        check("data_idle",    tx_data,  32'h0);
        check("data_clkpat",  clk_data, 16'hF0F0);

        // Three payload beats
        s_valid = 1'b1; s_data = 32'h11223344;
        step();
        check("beat0", tx_data, 32'h11223344);
        s_data = 32'h55667788;
        step();
        check("beat1", tx_data, 32'h55667788);
        s_data = 32'h99AABBCC;
        step();
        check("beat2", tx_data, 32'h99AABBCC);
        s_valid = 1'b0;
        step();
        check("fill",      tx_data,    32'h0);
        check("count3",    word_count, 32'd3);

        // train_req in DATA blocks acceptance
        s_valid = 1'b1; s_data = 32'hDEADBEEF; train_req = 1'b1;
        #1;
        check("treq_ready", s_ready, 1'b0);
        step();
        train_req = 1'b0; s_valid = 1'b0;
        check("retrain_state", tx_state,   2'b01);
        check("retrain_data",  tx_data,    {4{train_w}});
        check("retrain_count", word_count, 32'd3);
        for (int i = 1; i < TC; i++) begin
            step();
            check("retrain_hold", tx_state, 2'b01);
        end
        step();
        check("retrain_sync", tx_state, 2'b10);
        step();
        check("retrain_data_st", tx_state,   2'b11);
        check("retrain_count2",  word_count, 32'd3);

        // Drop enable at train count 4
        train_req = 1'b1;
        step();
        train_req = 1'b0;
        check("abort_train0", tx_state, 2'b01);
        step(); step(); step(); step();          // counter now 4
        check("abort_train4", tx_state, 2'b01);
        tx_enable = 1'b0;
        step();
        check("abort_idle",  tx_state, 2'b00);
        check("abort_data",  tx_data,  32'h0);
        check("abort_flag",  training, 1'b0);
        tx_enable = 1'b1;
        for (int i = 0; i < TC; i++) begin
            step();
            check("reen_train", tx_state, 2'b01);
        end
        step();
        check("reen_sync", tx_state, 2'b10);
        step();
        check("reen_data", tx_state, 2'b11);

        // word_count wrap
        force dut.word_count_q = 32'hFFFFFFFF;
        #1;
        release dut.word_count_q;
        #1;
        check("wrap_pre", word_count, 32'hFFFFFFFF);
        s_valid = 1'b1; s_data = 32'hA5A55A5A;
        step();
        s_valid = 1'b0;
        check("wrap_count", word_count, 32'd0);
        check("wrap_data",  tx_data,    32'hA5A55A5A);

        // Reset mid-DATA
        s_valid = 1'b1; s_data = 32'h01020304; reset = 1'b1;
        #1;
        check("rst_mid_ready", s_ready, 1'b0);
        step();
        check("rst_mid_state", tx_state,   2'b00);
        check("rst_mid_data",  tx_data,    32'h0);
        check("rst_mid_clk",   clk_data,   16'h0000);
        check("rst_mid_count", word_count, 32'd0);
        reset = 1'b0; s_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
